// File: rtl/top_commutation.sv
// Three-phase matrix-converter commutation: per output phase, a four-step
// current-safe transfer between inputs A/B/C plus a global latched short fault.
module top_commutation (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  shorts,
    input  logic [2:0]  CurrentSign,
    input  logic [5:0]  DesiredLoad,
    output logic [17:0] Sout,
    output logic        short
);

    typedef enum logic [1:0] {
        STEADY = 2'd0,
        S1     = 2'd1,
        S2     = 2'd2,
        S3     = 2'd3
    } step_t;

    localparam logic [1:0] NUL = 2'b00;

    // Gate pattern for one input of a 6-bit group: {fwd,rev} placed in the input's slot.
    function automatic logic [5:0] sw(input logic [1:0] conn, input logic f, input logic r);
        logic [5:0] g;
        g = 6'b000000;
        case (conn)
            2'b01:   g = {f, r, 4'b0000};
            2'b10:   g = {2'b00, f, r, 2'b00};
            2'b11:   g = {4'b0000, f, r};
            default: g = 6'b000000;
        endcase
        return g;
    endfunction

    logic fault;
    assign fault = short | (|shorts);

    // Fault latch: any short sets it and only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            short <= 1'b0;
        end else if (|shorts) begin
            short <= 1'b1;
        end else begin
            short <= short;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_phase
        step_t      step;
        logic [1:0] cur;
        logic [1:0] tgt;
        logic       sgn;
        logic [5:0] grp;
        logic [1:0] des;
        logic       cs;

        assign des = DesiredLoad[2*i+1 -: 2];
        assign cs  = CurrentSign[i];

        // Per-phase commutation sequencer; the gate group is produced directly by this register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                step <= STEADY;
                cur  <= NUL;
                tgt  <= NUL;
                sgn  <= 1'b0;
                grp  <= 6'b000000;
            end else if (fault || !start) begin
                step <= STEADY;
                cur  <= NUL;
                tgt  <= NUL;
                sgn  <= 1'b0;
                grp  <= 6'b000000;
            end else begin
                case (step)
                    STEADY: begin
                        if (des != cur) begin
                            tgt  <= des;
                            sgn  <= cs;
                            step <= S1;
                            // Leaving NUL turns on the new conducting switch, otherwise drop the old non-conducting one.
                            grp  <= (cur == NUL) ? sw(des, cs, ~cs) : sw(cur, cs, ~cs);
                        end else begin
                            grp  <= sw(cur, 1'b1, 1'b1);
                        end
                    end
                    S1: begin
                        if ((cur == NUL) || (tgt == NUL)) begin
                            cur  <= tgt;
                            step <= STEADY;
                            grp  <= sw(tgt, 1'b1, 1'b1);
                        end else begin
                            step <= S2;
                            grp  <= sw(cur, sgn, ~sgn) | sw(tgt, sgn, ~sgn);
                        end
                    end
                    S2: begin
                        step <= S3;
                        grp  <= sw(tgt, sgn, ~sgn);
                    end
                    S3: begin
                        cur  <= tgt;
                        step <= STEADY;
                        grp  <= sw(tgt, 1'b1, 1'b1);
                    end
                    default: begin
                        step <= STEADY;
                        cur  <= NUL;
                        tgt  <= NUL;
                        sgn  <= 1'b0;
                        grp  <= 6'b000000;
                    end
                endcase
            end
        end

        assign Sout[6*i+5 -: 6] = grp;
    end

endmodule

// File: tb/tb_top_commutation.sv
// Self-checking bench for top_commutation: directed scenarios plus randomized
// traffic compared against a sequence-list reference model.
module tb_top_commutation;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  shorts = 3'b000;
    logic [2:0]  CurrentSign = 3'b000;
    logic [5:0]  DesiredLoad = 6'b000000;
    logic [17:0] Sout;
    logic        short;

    int nvec = 0;
    int nerr = 0;

    // Reference model: each commutation is expanded into its list of group patterns up front.
    int         m_cur [3];
    logic [5:0] m_pend [3][4];
    int         m_len [3];
    int         m_pos [3];
    logic [5:0] m_exp [3];
    bit         m_short;

    always #5 clk = ~clk;

    top_commutation dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .shorts      (shorts),
        .CurrentSign (CurrentSign),
        .DesiredLoad (DesiredLoad),
        .Sout        (Sout),
        .short       (short)
    );

    function automatic logic [5:0] pat(int conn, bit f, bit r);
        logic [5:0] v;
        v = 6'd0;
        if (conn != 0) begin
            v[7 - 2*conn] = f;
            v[6 - 2*conn] = r;
        end
        return v;
    endfunction

    function automatic logic [18:0] m_out();
        return {m_short, m_exp[2], m_exp[1], m_exp[0]};
    endfunction

    task automatic model_clear();
        for (int p = 0; p < 3; p++) begin
            m_cur[p] = 0;
            m_len[p] = 0;
            m_pos[p] = 0;
            m_exp[p] = 6'd0;
        end
    endtask

    task automatic model_reset();
        m_short = 1'b0;
        model_clear();
    endtask

    task automatic model_edge();
        int d;
        int x;
        bit s;
        if (m_short || (shorts != 3'b000)) begin
            m_short = 1'b1;
            model_clear();
        end else if (!start) begin
            model_clear();
        end else begin
            for (int p = 0; p < 3; p++) begin
                d = int'((DesiredLoad >> (2*p)) & 6'd3);
                s = CurrentSign[p];
                x = m_cur[p];
                if (m_pos[p] < m_len[p]) begin
                    m_exp[p] = m_pend[p][m_pos[p]];
                    m_pos[p]++;
                end else if (d != x) begin
                    if (x == 0) begin
                        m_pend[p][0] = pat(d, s, !s);
                        m_pend[p][1] = pat(d, 1, 1);
                        m_len[p] = 2;
                    end else if (d == 0) begin
                        m_pend[p][0] = pat(x, s, !s);
                        m_pend[p][1] = 6'd0;
                        m_len[p] = 2;
                    end else begin
                        m_pend[p][0] = pat(x, s, !s);
                        m_pend[p][1] = pat(x, s, !s) | pat(d, s, !s);
                        m_pend[p][2] = pat(d, s, !s);
                        m_pend[p][3] = pat(d, 1, 1);
                        m_len[p] = 4;
                    end
                    m_exp[p] = m_pend[p][0];
                    m_pos[p] = 1;
                    m_cur[p] = d;
                end else begin
                    m_exp[p] = pat(x, 1, 1);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        DesiredLoad = 6'b000000;
        start = 1'b0;
        do_reset();
        nvec++;
        if ({short, Sout} !== 19'd0) begin
            nerr++;
            $display("FAIL reset_release: got %b expected %b", {short, Sout}, 19'd0);
        end
        start = 1'b1;
        repeat (2) begin
            step();
            nvec++;
            if ({short, Sout} !== 19'd0) begin
                nerr++;
                $display("FAIL reset_nul_idle: got %b expected %b", {short, Sout}, 19'd0);
            end
        end
    endtask

    task automatic test_power_up();
        start = 1'b0;
        DesiredLoad = 6'b011011;
        CurrentSign = 3'b111;
        repeat (4) begin
            step();
            nvec++;
            if (Sout !== 18'd0) begin
                nerr++;
                $display("FAIL start_low_hold: got %b expected %b", Sout, 18'd0);
            end
        end
        start = 1'b1;
        step();
        nvec++;
        if (Sout !== 18'b100000_001000_000010) begin
            nerr++;
            $display("FAIL powerup_edge1: got %b expected %b", Sout, 18'b100000_001000_000010);
        end
        step();
        nvec++;
        if (Sout !== 18'b110000_001100_000011) begin
            nerr++;
            $display("FAIL powerup_edge2: got %b expected %b", Sout, 18'b110000_001100_000011);
        end
    endtask

    task automatic test_commutation();
        logic [5:0] e1 [4];
        e1 = '{6'b100000, 6'b101000, 6'b001000, 6'b001100};
        DesiredLoad = 6'b101101;
        CurrentSign = 3'b111;
        for (int k = 0; k < 4; k++) begin
            step();
            nvec++;
            if (Sout[17:12] !== e1[k]) begin
                nerr++;
                $display("FAIL commut_pos_step%0d: got %b expected %b", k, Sout[17:12], e1[k]);
            end
        end
        nvec++;
        if (Sout !== 18'b001100_000011_110000) begin
            nerr++;
            $display("FAIL commut_pos_final: got %b expected %b", Sout, 18'b001100_000011_110000);
        end
    endtask

    task automatic test_neg_sign();
        logic [5:0] e1 [4];
        e1 = '{6'b010000, 6'b010100, 6'b000100, 6'b001100};
        DesiredLoad = 6'b011011;
        CurrentSign = 3'b000;
        repeat (4) step();
        nvec++;
        if (Sout !== 18'b110000_001100_000011) begin
            nerr++;
            $display("FAIL neg_return: got %b expected %b", Sout, 18'b110000_001100_000011);
        end
        DesiredLoad = 6'b101101;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 0) begin
                // Changes mid-sequence must not disturb the transfer already under way.
                DesiredLoad = 6'b111111;
                CurrentSign = 3'b111;
            end
            nvec++;
            if (Sout[17:12] !== e1[k]) begin
                nerr++;
                $display("FAIL commut_neg_step%0d: got %b expected %b", k, Sout[17:12], e1[k]);
            end
        end
        nvec++;
        if (Sout !== 18'b001100_000011_110000) begin
            nerr++;
            $display("FAIL commut_neg_final: got %b expected %b", Sout, 18'b001100_000011_110000);
        end
        DesiredLoad = 6'b101101;
    endtask

    task automatic test_start_drop();
        DesiredLoad = 6'b011011;
        CurrentSign = 3'b101;
        step();
        step();
        start = 1'b0;
        step();
        nvec++;
        if (Sout !== 18'd0) begin
            nerr++;
            $display("FAIL start_drop: got %b expected %b", Sout, 18'd0);
        end
        start = 1'b1;
        DesiredLoad = 6'b110000;
        CurrentSign = 3'b111;
        step();
        nvec++;
        if (Sout !== 18'b000010_000000_000000) begin
            nerr++;
            $display("FAIL nul_to_c_edge1: got %b expected %b", Sout, 18'b000010_000000_000000);
        end
        step();
        nvec++;
        if (Sout !== 18'b000011_000000_000000) begin
            nerr++;
            $display("FAIL nul_to_c_edge2: got %b expected %b", Sout, 18'b000011_000000_000000);
        end
    endtask

    task automatic test_random();
        start = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(3, 0) == 0) DesiredLoad = 6'($urandom);
            CurrentSign = 3'($urandom);
            start = ($urandom_range(15, 0) != 0);
            step();
            nvec++;
            if ({short, Sout} !== m_out()) begin
                nerr++;
                $display("FAIL random_%0d: got %b expected %b", n, {short, Sout}, m_out());
            end
        end
    endtask

    task automatic test_short();
        start = 1'b1;
        DesiredLoad = 6'b011011;
        CurrentSign = 3'b111;
        repeat (8) step();
        nvec++;
        if (Sout !== 18'b110000_001100_000011) begin
            nerr++;
            $display("FAIL pre_short_steady: got %b expected %b", Sout, 18'b110000_001100_000011);
        end
        shorts = 3'b010;
        DesiredLoad = 6'b101101;
        step();
        nvec++;
        if ({short, Sout} !== {1'b1, 18'd0}) begin
            nerr++;
            $display("FAIL short_trip: got %b expected %b", {short, Sout}, {1'b1, 18'd0});
        end
        shorts = 3'b000;
        for (int n = 0; n < 6; n++) begin
            DesiredLoad = 6'($urandom);
            start = $urandom_range(1, 0) == 1;
            step();
            nvec++;
            if ({short, Sout} !== {1'b1, 18'd0}) begin
                nerr++;
                $display("FAIL short_hold_%0d: got %b expected %b", n, {short, Sout}, {1'b1, 18'd0});
            end
        end
        start = 1'b0;
        do_reset();
        nvec++;
        if ({short, Sout} !== 19'd0) begin
            nerr++;
            $display("FAIL short_cleared: got %b expected %b", {short, Sout}, 19'd0);
        end
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        DesiredLoad = 6'b011011;
        CurrentSign = 3'b000;
        repeat (3) step();
        DesiredLoad = 6'b101101;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        nvec++;
        if ({short, Sout} !== 19'd0) begin
            nerr++;
            $display("FAIL async_reset: got %b expected %b", {short, Sout}, 19'd0);
        end
        DesiredLoad = 6'b000000;
        do_reset();
        step();
        nvec++;
        if ({short, Sout} !== 19'd0) begin
            nerr++;
            $display("FAIL post_reset_idle: got %b expected %b", {short, Sout}, 19'd0);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_power_up();
        test_commutation();
        test_neg_sign();
        test_start_drop();
        test_random();
        test_short();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/top_commutation.md
TOP_COMMUTATION -- requirements
Module: top_commutation

Interface
REQ-001 SHALL have ports, one per line:
  clk  input  1  sole clock, all state on rising edge
  rst  input  1  asynchronous active-high reset
  start  input  1  level enable; 0 = all switches off, FSMs held idle
  shorts  input  3  short-circuit detect per output phase ([2]=phase1, [1]=phase2, [0]=phase3)
  CurrentSign  input  3  load-current sign per output phase (1 = positive/forward, 0 = negative), same bit mapping
  DesiredLoad  input  6  requested input connection per output phase ([5:4]=phase1, [3:2]=phase2, [1:0]=phase3); 2'b00 NUL, 01 input A, 10 input B, 11 input C
  Sout  output  18  switch gates, registered ([17:12]=phase1, [11:6]=phase2, [5:0]=phase3)
  short  output  1  latched fault flag, registered
REQ-002 SHALL use one clock (clk); reset rst SHALL be asynchronous and active-high.
REQ-003 SHALL order each 6-bit Sout group as [5:4]=input A {fwd,rev}, [3:2]=input B {fwd,rev}, [1:0]=input C {fwd,rev}; fwd conducts positive current, rev negative.

Function
REQ-004 SHALL contain three identical, independent per-phase commutation FSMs plus one global fault latch.
REQ-005 Per-phase state SHALL be: current connection CUR (NUL/A/B/C), target TGT, step state in {STEADY, S1, S2, S3}.
REQ-006 In STEADY, CUR=X≠NUL SHALL drive both fwd and rev of X =1, all other bits of the group 0; CUR=NUL SHALL drive group = 0.
REQ-007 In STEADY with start=1, DesiredLoad field ≠ CUR SHALL be latched into TGT and stepping begins next edge; DesiredLoad changes during stepping SHALL be ignored until STEADY is re-entered.
REQ-008 Commutation X→Y (both ≠ NUL) SHALL be four-step, one clock per step, using CurrentSign sampled when leaving STEADY: conducting switch c = fwd if sign=1 else rev, non-conducting n = the other. S1: X.n off. S2: Y.c on. S3: X.c off. Next edge: Y.n on, CUR=Y, STEADY.
REQ-009 NUL→Y SHALL be two-step: S1: Y.c on; next edge: Y both on, CUR=Y, STEADY.
REQ-010 X→NUL SHALL be two-step: S1: X.n off; next edge: group 0, CUR=NUL, STEADY.
REQ-011 Hence, with start=1 from all-NUL, Sout SHALL reach fully-on target pattern exactly 2 rising edges after the DesiredLoad/start condition is sampled; X→Y SHALL complete in 4 edges.
REQ-012 At no cycle SHALL a group have more than one input with both switches on, nor a non-conducting switch of two inputs on simultaneously.
REQ-013 start=0 SHALL force next-edge Sout=0, all CUR=NUL, all FSMs STEADY (hard off, no sequencing).
REQ-014 Any shorts bit =1 on a rising edge SHALL set short=1 and force Sout=0 on that same edge; short and Sout=0 SHALL persist, regardless of start/shorts/DesiredLoad, until rst.
REQ-015 Simultaneous shorts and start/DesiredLoad change SHALL give fault priority.
REQ-016 Sout and short SHALL be register outputs, no combinational input-to-output path.

Reset
REQ-017 rst=1 SHALL asynchronously clear Sout=18'b0, short=0, all CUR=TGT=NUL, all states STEADY; rst mid-commutation SHALL abort immediately to these values.
REQ-018 After rst release, outputs SHALL stay 0 until start=1 and a non-NUL DesiredLoad field is sampled.

Verification
REQ-019 rst pulse, DesiredLoad=000000, start=0 -> Sout=0, short=0 after release.
REQ-020 DesiredLoad={A,B,C}=011011, start=0 for 4 clocks -> Sout stays 0; then start=1, CurrentSign=111 -> after 1 edge Sout=100000_001000_000010, after 2 edges Sout=110000_001100_000011.
REQ-021 From steady {A,B,C}, set DesiredLoad={B,C,A}=101101, CurrentSign=111 -> phase1 group per edge: 100000, 101000, 001000, 001100; final Sout=001100_000011_110000 after 4 edges.
REQ-022 Same as REQ-021 with CurrentSign=000 -> phase1 sequence 010000, 010100, 000100, 001100.
REQ-023 Steady nonzero Sout, shorts=010 one cycle -> next edge Sout=0, short=1; held after shorts=000 until rst.
REQ-024 start dropped mid-commutation -> Sout=0 next edge; rst asserted mid-commutation -> Sout=0 immediately (asynchronous).
